// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit/receive blocks.
//   Contents:
//     - DATA_BITS      : bits per UART character
//     - uart_state_e   : frame-sequencer state encoding
//     - clog2()        : width helper for the baud counter
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   // Ceiling log2: number of bits needed to hold the values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
//   Free-running bit-period counter. It counts 0..CLKS_PER_BIT-1 and raises
//   tick for exactly one cycle, on the count CLKS_PER_BIT-1.
//   Ports:
//     clock  in   single clock, posedge
//     reset  in   synchronous, active-high; clears the count
//     clear  in   holds/restarts the count at zero
//     tick   out  one-cycle pulse at the end of each bit period
// ---------------------------------------------------------------------------
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == CNT_MAX);

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments only; blocking ones
   // here would make the result depend on process evaluation order.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/axis_uart_tx.sv
// ---------------------------------------------------------------------------
// axis_uart_tx
//   AXI-stream byte sink that serializes each accepted byte as an 8N1/8N2
//   UART frame (start bit, 8 data bits LSB first, STOP_BITS stop bits).
//   A handshake in the last cycle of the last stop bit chains straight into
//   the next start bit, so a held ivalid gives gap-free back-to-back frames.
//   Ports:
//     clock   in   single clock, posedge
//     reset   in   synchronous, active-high
//     idata   in   stream byte, sampled on ivalid && iready
//     ivalid  in   upstream has a byte
//     iready  out  byte accepted this cycle if ivalid (depends on state only)
//     txd     out  registered UART line, idle high
//     busy    out  frame in progress
// ---------------------------------------------------------------------------
module axis_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] idata,
   input  logic                 ivalid,
   output logic                 iready,
   output logic                 txd,
   output logic                 busy
);

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [3:0]           bitcnt_q, bitcnt_d;
   logic                 txd_q, txd_d;

   logic tick;
   logic last_stop;
   logic handshake;

   // The baud counter is parked at zero while idle, so the start bit of a
   // frame accepted from IDLE lasts exactly CLKS_PER_BIT cycles. When frames
   // chain, the counter wraps to zero on its own.
   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clock(clock),
      .reset(reset),
      .clear(state_q == ST_IDLE),
      .tick (tick)
   );

   assign last_stop = (state_q == ST_STOP) && (bitcnt_q == LAST_STOP) && tick;

   // iready looks only at state, counters and reset, never at ivalid, so it
   // cannot form a combinational loop with an upstream FIFO.
   assign iready    = !reset && ((state_q == ST_IDLE) || last_stop);
   assign handshake = ivalid && iready;
   assign busy      = (state_q != ST_IDLE);
   assign txd       = txd_q;

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               state_d = ST_START;
               shift_d = idata;
            end
         end

         ST_START: begin
            if (tick) begin
               state_d  = ST_DATA;
               bitcnt_d = '0;
            end
         end

         ST_DATA: begin
            if (tick) begin
               if (bitcnt_q == LAST_DATA) begin
                  state_d  = ST_STOP;
                  bitcnt_d = '0;
               end else begin
                  bitcnt_d = bitcnt_q + 4'd1;
                  shift_d  = shift_q >> 1;
               end
            end
         end

         ST_STOP: begin
            if (tick) begin
               if (bitcnt_q == LAST_STOP) begin
                  bitcnt_d = '0;
                  if (handshake) begin
                     state_d = ST_START;
                     shift_d = idata;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bitcnt_d = bitcnt_q + 4'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // The line level is decoded from the next state and registered, so txd
   // changes in the same cycle the state does and has no path from idata.
   always_comb begin
      txd_d = 1'b1;
      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shift_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         bitcnt_q <= '0;
         txd_q    <= 1'b1;
         // NOTE: the shift register is a handful of plain flops, not a RAM,
         // so it is reset with the control state to keep X off the line.
         shift_q  <= '0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         txd_q    <= txd_d;
         shift_q  <= shift_d;
      end
   end

endmodule
